ifetch_prefetch: RTL and testbench

Parametrised instruction fetch unit with an internal prefetch FIFO. It issues one word fetch at a time to the memory bus arbiter and buffers returned instructions with their PCs. Entries drain to the instruction queue over a valid/ready handshake. It accepts ROB redirects at any time, including while a bus transaction is outstanding, and sits between the memory bus arbiter and the instruction queue.

---
 rtl/ifetch_prefetch_pkg.sv | 29 ++
 rtl/ifetch_fifo.sv | 70 +++++++
 rtl/ifetch_prefetch.sv | 146 ++++++++++++++
 tb/tb_ifetch_prefetch.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// The JAL immediate helper exists only when IFETCH_JAL_PREDICT_EN is defined.
package ifetch_prefetch_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_INST_W  = 32;
    localparam int unsigned DEF_DEPTH   = 4;
    localparam int unsigned DEF_PC_STEP = 4;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } state_e;

`ifdef IFETCH_JAL_PREDICT_EN
    // J-type immediate, bit 0 implied zero; caller sign-extends from bit 20.
    function automatic logic [20:0] jal_imm(input logic [31:0] inst);
        return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction
`endif

endpackage

// File: rtl/ifetch_fifo.sv
// Circular prefetch buffer with a registered head, flush and occupancy count.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ifetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_nxt;
    logic [PW-1:0] rd_nxt;
    logic [PW-1:0] cnt_nxt;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == PW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign do_push = push && (!full || do_pop);
    assign wr_nxt  = wr_ptr + PW'(do_push);
    assign rd_nxt  = rd_ptr + PW'(do_pop);
    assign cnt_nxt = wr_nxt - rd_nxt;

    always_ff @(posedge clk_in) begin
        if (do_push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Head register: bypass the incoming word when it becomes the new head.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_valid <= 1'b0;
        end else begin
            wr_ptr     <= wr_nxt;
            rd_ptr     <= rd_nxt;
            head_valid <= (cnt_nxt != '0);
            if (cnt_nxt != '0) begin
                if (do_push && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) begin
                    head_data <= push_data;
                end else begin
                    head_data <= mem[rd_nxt[AW-1:0]];
                end
            end
        end
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction fetch unit: one outstanding bus fetch, prefetch FIFO, ROB redirect.
// Define IFETCH_JAL_PREDICT_EN to follow JAL targets and flag them on iq_pred_out.
module ifetch_prefetch
    import ifetch_prefetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned INST_W  = DEF_INST_W,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned PC_STEP = DEF_PC_STEP
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    output logic              mem_req_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic              mem_gnt_in,
    input  logic              mem_valid_in,
    input  logic [INST_W-1:0] mem_data_in,
    output logic              iq_valid_out,
    output logic [INST_W-1:0] iq_inst_out,
    output logic [ADDR_W-1:0] iq_pc_out,
    output logic              iq_pred_out,
    input  logic              iq_ready_in,
    input  logic              redirect_en_in,
    input  logic [ADDR_W-1:0] redirect_pc_in
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
`ifdef IFETCH_JAL_PREDICT_EN
    localparam int unsigned ENTRY_W = 1 + INST_W + ADDR_W;
`else
    localparam int unsigned ENTRY_W = INST_W + ADDR_W;
`endif

    state_e              state;
    logic [ADDR_W-1:0]   fetch_pc;
    logic                pend_valid;
    logic [INST_W-1:0]   pend_data;

    logic                redirect;
    logic                ret_valid;
    logic [INST_W-1:0]   ret_data;
    logic                push;
    logic                pop;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_after;
    logic [ADDR_W-1:0]   next_pc;
    logic [ENTRY_W-1:0]  push_entry;
    logic [ENTRY_W-1:0]  head_entry;
    logic                head_valid;

    // A return captured while frozen is replayed on the first ready cycle.
    assign redirect    = rdy_in && redirect_en_in;
    assign ret_valid   = rdy_in && (mem_valid_in || pend_valid);
    assign ret_data    = pend_valid ? pend_data : mem_data_in;
    assign pop         = rdy_in && head_valid && iq_ready_in;
    assign push        = ret_valid && (state == ST_WAIT) && !redirect;
    assign count_after = count + CNT_W'(1) - CNT_W'(pop);

`ifdef IFETCH_JAL_PREDICT_EN
    logic               is_jal;
    logic signed [20:0] imm;

    assign is_jal      = (ret_data[6:0] == OPC_JAL);
    assign imm         = jal_imm(ret_data[31:0]);
    assign next_pc     = is_jal ? (fetch_pc + ADDR_W'(imm)) : (fetch_pc + ADDR_W'(PC_STEP));
    assign push_entry  = {is_jal, ret_data, fetch_pc};
    assign iq_pred_out = head_entry[ENTRY_W-1];
`else
    assign next_pc     = fetch_pc + ADDR_W'(PC_STEP);
    assign push_entry  = {ret_data, fetch_pc};
    assign iq_pred_out = 1'b0;
`endif

    assign mem_req_out  = rdy_in && (state == ST_REQ);
    assign mem_addr_out = fetch_pc;
    assign iq_valid_out = head_valid;
    assign iq_inst_out  = head_entry[ADDR_W +: INST_W];
    assign iq_pc_out    = head_entry[ADDR_W-1:0];

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .flush      (redirect),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_entry),
        .count      (count)
    );

    // Fetch control; a return seen in the redirect cycle closes the old transaction.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state      <= ST_IDLE;
            fetch_pc   <= '0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else if (!rdy_in) begin
            if (mem_valid_in && ((state == ST_WAIT) || (state == ST_DROP))) begin
                pend_valid <= 1'b1;
                pend_data  <= mem_data_in;
            end
        end else begin
            pend_valid <= 1'b0;
            if (redirect) begin
                fetch_pc <= redirect_pc_in;
                unique case (state)
                    ST_WAIT, ST_DROP: state <= ret_valid ? ST_REQ : ST_DROP;
                    ST_REQ:           state <= mem_gnt_in ? ST_DROP : ST_REQ;
                    default:          state <= ST_REQ;
                endcase
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (count < CNT_W'(DEPTH)) begin
                            state <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (mem_gnt_in) begin
                            state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (ret_valid) begin
                            fetch_pc <= next_pc;
                            state    <= (count_after < CNT_W'(DEPTH)) ? ST_REQ : ST_IDLE;
                        end
                    end
                    ST_DROP: begin
                        if (ret_valid) begin
                            state <= ST_REQ;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Self-checking bench for ifetch_prefetch: bus responder model plus PC-stream scoreboard.
// Honours IFETCH_JAL_PREDICT_EN for the expected JAL behaviour.
module tb_ifetch_prefetch;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INST_W  = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PC_STEP = 4;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic              rdy_in;
    logic              mem_req_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic              mem_gnt_in;
    logic              mem_valid_in;
    logic [INST_W-1:0] mem_data_in;
    logic              iq_valid_out;
    logic [INST_W-1:0] iq_inst_out;
    logic [ADDR_W-1:0] iq_pc_out;
    logic              iq_pred_out;
    logic              iq_ready_in;
    logic              redirect_en_in;
    logic [ADDR_W-1:0] redirect_pc_in;

    always #5 clk_in = ~clk_in;

    ifetch_prefetch #(
        .ADDR_W  (ADDR_W),
        .INST_W  (INST_W),
        .DEPTH   (DEPTH),
        .PC_STEP (PC_STEP)
    ) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .rdy_in         (rdy_in),
        .mem_req_out    (mem_req_out),
        .mem_addr_out   (mem_addr_out),
        .mem_gnt_in     (mem_gnt_in),
        .mem_valid_in   (mem_valid_in),
        .mem_data_in    (mem_data_in),
        .iq_valid_out   (iq_valid_out),
        .iq_inst_out    (iq_inst_out),
        .iq_pc_out      (iq_pc_out),
        .iq_pred_out    (iq_pred_out),
        .iq_ready_in    (iq_ready_in),
        .redirect_en_in (redirect_en_in),
        .redirect_pc_in (redirect_pc_in)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          grants;
    int          pops;
    logic [31:0] last_gaddr;
    bit          outstanding;
    int          rem;
    logic [31:0] odata;
    int          lat_cfg;
    bit          lat_rand;
    bit          bad_next;
    bit          jal_mode;
    logic [31:0] exp_pc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory image: every word is an addi-type encoding unique to its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (jal_mode && (a == 32'h20)) return 32'h0080006F;
        return {a[24:0] ^ 25'h1A5A5A5, 7'h13};
    endfunction

    function automatic logic [31:0] exp_next(input logic [31:0] pc, input logic [31:0] inst);
`ifdef IFETCH_JAL_PREDICT_EN
        if (inst[6:0] == 7'h6F)
            return pc + {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
`endif
        return pc + 32'(PC_STEP);
    endfunction

    function automatic logic exp_pred(input logic [31:0] inst);
`ifdef IFETCH_JAL_PREDICT_EN
        return inst[6:0] == 7'h6F;
`else
        return 1'b0 & inst[0];
`endif
    endfunction

    // One clock: observe handshakes mid-cycle, then advance the bus responder.
    task automatic cycle();
        bit          g, p, rd;
        logic [31:0] ga, ppc, pinst;
        logic        ppred;
        @(negedge clk_in);
        g     = rst_n_in && mem_req_out && mem_gnt_in;
        ga    = mem_addr_out;
        p     = rst_n_in && rdy_in && iq_valid_out && iq_ready_in;
        ppc   = iq_pc_out;
        pinst = iq_inst_out;
        ppred = iq_pred_out;
        rd    = rst_n_in && rdy_in && redirect_en_in;
        if (!rdy_in) check("req_frozen", mem_req_out, 0);
        if (p && !rd) begin
            pops++;
            check("pop_pc", ppc, exp_pc);
            check("pop_inst", pinst, mem_word(ppc));
            check("pop_pred", ppred, exp_pred(pinst));
            exp_pc = exp_next(ppc, pinst);
        end
        if (rd) exp_pc = redirect_pc_in;
        @(posedge clk_in);
        #1;
        mem_valid_in = 1'b0;
        if (!rst_n_in) begin
            outstanding = 1'b0;
        end else begin
            if (g) check("one_outstanding", outstanding, 0);
            if (outstanding) begin
                rem--;
                if (rem <= 0) begin
                    mem_valid_in = 1'b1;
                    mem_data_in  = odata;
                    outstanding  = 1'b0;
                end
            end
            if (g) begin
                grants++;
                last_gaddr  = ga;
                outstanding = 1'b1;
                rem         = lat_rand ? int'($urandom_range(1, 3)) : lat_cfg;
                odata       = bad_next ? 32'hDEADBEEF : mem_word(ga);
                bad_next    = 1'b0;
            end
        end
    endtask

    task automatic do_reset(input bit check_values);
        rst_n_in       = 1'b0;
        rdy_in         = 1'b1;
        redirect_en_in = 1'b0;
        redirect_pc_in = '0;
        iq_ready_in    = 1'b0;
        mem_gnt_in     = 1'b0;
        mem_valid_in   = 1'b0;
        mem_data_in    = '0;
        cycle();
        cycle();
        if (check_values) begin
            check("rst_req", mem_req_out, 0);
            check("rst_addr", mem_addr_out, 0);
            check("rst_valid", iq_valid_out, 0);
            check("rst_inst", iq_inst_out, 0);
            check("rst_pc", iq_pc_out, 0);
            check("rst_pred", iq_pred_out, 0);
        end
        rst_n_in    = 1'b1;
        outstanding = 1'b0;
        exp_pc      = '0;
        grants      = 0;
        pops        = 0;
        bad_next    = 1'b0;
        jal_mode    = 1'b0;
        lat_rand    = 1'b0;
        lat_cfg     = 1;
    endtask

    task automatic wait_grants(input int n, input string tag);
        for (int i = 0; i < 300 && grants < n; i++) cycle();
        check(tag, grants >= n, 1);
    endtask

    task automatic wait_pops(input int n, input string tag);
        for (int i = 0; i < 300 && pops < n; i++) cycle();
        check(tag, pops >= n, 1);
    endtask

    initial begin
        int p0;

        // Streaming: 0x0, 0x4, 0x8 in order
        do_reset(1'b1);
        iq_ready_in = 1'b1;
        mem_gnt_in  = 1'b1;
        wait_pops(3, "stream_progress");

        // Backpressure: exactly DEPTH grants then idle, resume at 0x10
        do_reset(1'b0);
        mem_gnt_in = 1'b1;
        repeat (40) cycle();
        check("bp_grants", grants, DEPTH);
        check("bp_req_idle", mem_req_out, 0);
        check("bp_valid", iq_valid_out, 1);
        iq_ready_in = 1'b1;
        wait_grants(DEPTH + 1, "bp_resume_timeout");
        check("bp_resume_addr", last_gaddr, 32'h10);
        repeat (20) cycle();

        // Redirect in WAIT: stale 0xDEADBEEF must not surface
        do_reset(1'b0);
        mem_gnt_in = 1'b1;
        wait_grants(2, "rw_fill_timeout");
        lat_cfg  = 3;
        bad_next = 1'b1;
        wait_grants(3, "rw_wait_timeout");
        redirect_en_in = 1'b1;
        redirect_pc_in = 32'h100;
        cycle();
        redirect_en_in = 1'b0;
        check("rw_flush_valid", iq_valid_out, 0);
        lat_cfg = 1;
        wait_grants(4, "rw_refetch_timeout");
        check("rw_refetch_addr", last_gaddr, 32'h100);
        iq_ready_in = 1'b1;
        p0 = pops;
        repeat (30) cycle();
        check("rw_progress", pops > p0, 1);

        // Redirect together with push and pop
        do_reset(1'b0);
        mem_gnt_in = 1'b1;
        lat_cfg    = 2;
        for (int i = 0; i < 300 && !(grants == DEPTH && mem_valid_in); i++) cycle();
        check("rpp_setup", (grants == DEPTH) && mem_valid_in, 1);
        iq_ready_in    = 1'b1;
        redirect_en_in = 1'b1;
        redirect_pc_in = 32'h200;
        cycle();
        redirect_en_in = 1'b0;
        iq_ready_in    = 1'b0;
        check("rpp_flush_valid", iq_valid_out, 0);
        wait_grants(DEPTH + 1, "rpp_refetch_timeout");
        check("rpp_refetch_addr", last_gaddr, 32'h200);
        iq_ready_in = 1'b1;
        repeat (20) cycle();

        // Freeze across a return: delivered once after rdy_in comes back
        do_reset(1'b0);
        iq_ready_in = 1'b1;
        mem_gnt_in  = 1'b1;
        wait_grants(1, "frz_grant_timeout");
        rdy_in = 1'b0;
        repeat (3) cycle();
        rdy_in = 1'b1;
        wait_pops(2, "frz_progress");
        repeat (10) cycle();

        // JAL at 0x20
        do_reset(1'b0);
        jal_mode       = 1'b1;
        iq_ready_in    = 1'b1;
        mem_gnt_in     = 1'b1;
        redirect_en_in = 1'b1;
        redirect_pc_in = 32'h20;
        cycle();
        redirect_en_in = 1'b0;
        wait_grants(1, "jal_grant_timeout");
        check("jal_first_addr", last_gaddr, 32'h20);
        wait_grants(2, "jal_next_timeout");
`ifdef IFETCH_JAL_PREDICT_EN
        check("jal_next_addr", last_gaddr, 32'h28);
`else
        check("jal_next_addr", last_gaddr, 32'h24);
`endif
        wait_pops(2, "jal_progress");

        // Randomized traffic
        do_reset(1'b0);
        lat_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            mem_gnt_in     = ($urandom_range(0, 9) < 7);
            iq_ready_in    = ($urandom_range(0, 9) < 7);
            rdy_in         = ($urandom_range(0, 9) < 9);
            redirect_en_in = ($urandom_range(0, 39) == 0);
            redirect_pc_in = 32'($urandom_range(0, 255)) << 2;
            cycle();
        end
        redirect_en_in = 1'b0;
        rdy_in         = 1'b1;
        mem_gnt_in     = 1'b1;
        iq_ready_in    = 1'b1;
        p0 = pops;
        repeat (60) cycle();
        check("rand_drain_progress", (pops - p0) >= 5, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
